// File: rtl/clk_mon_pkg.sv
// rtl/clk_mon_pkg.sv - shared types and constants for the clock period monitor
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } mon_state_t;

    localparam int ERR_W = 8;

    localparam int DEF_CNT_W    = 16;
    localparam int DEF_EXP_HIGH = 25;
    localparam int DEF_EXP_LOW  = 25;
    localparam int DEF_TOL      = 1;
    localparam int DEF_LOCK_N   = 4;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchronizer with registered rise/fall pulses
module sync_edge_det (
    input  logic clock,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic sync_d;

    // Synchronize sig_in, keep one delayed copy, and register one-cycle edge pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            sync_d <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta_q <= sig_in;
            sync_q <= meta_q;
            sync_d <= sync_q;
            rise   <= sync_q & ~sync_d;
            fall   <= ~sync_q & sync_d;
        end
    end

endmodule

// File: rtl/clk_period_monitor.sv
// rtl/clk_period_monitor.sv - measures high/low widths of sig_in and checks each period
module clk_period_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int EXP_HIGH = DEF_EXP_HIGH,
    parameter int EXP_LOW  = DEF_EXP_LOW,
    parameter int TOL      = DEF_TOL,
    parameter int LOCK_N   = DEF_LOCK_N
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             sig_in,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_low,
    output logic             meas_valid,
    output logic             period_err,
    output logic             timeout,
    output logic [ERR_W-1:0] err_count,
    output logic             locked
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
    localparam int                LOCK_W   = $clog2(LOCK_N + 1);
    localparam logic [LOCK_W-1:0] LOCK_TGT = LOCK_W'(LOCK_N);

    mon_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  high_hold;
    logic [LOCK_W-1:0] lock_cnt;

    logic rise;
    logic fall;
    logic period_good;
    logic chk_good;
    logic chk_bad;
    logic sat_hit;

    sync_edge_det u_sync_edge_det (
        .clock   (clock),
        .reset_n (reset_n),
        .sig_in  (sig_in),
        .rise    (rise),
        .fall    (fall)
    );

    // Magnitude difference is taken one bit wider than the counter so it never wraps.
    function automatic logic within_tol(input logic [CNT_W-1:0] width, input int exp_w);
        logic [CNT_W:0] w;
        logic [CNT_W:0] e;
        logic [CNT_W:0] d;
        w = {1'b0, width};
        e = (CNT_W + 1)'(exp_w);
        d = (w >= e) ? (w - e) : (e - w);
        return (d <= (CNT_W + 1)'(TOL));
    endfunction

    // The period check looks at the freshly published measurement, so it runs
    // while meas_valid is high and its effects land on the following clock.
    assign period_good = within_tol(meas_high, EXP_HIGH) && within_tol(meas_low, EXP_LOW);
    assign chk_good    = meas_valid && period_good;
    assign chk_bad     = meas_valid && !period_good;

    // Saturation takes priority over any edge arriving on the same cycle.
    assign sat_hit = enable && ((state == HIGH) || (state == LOW)) && (cnt == CNT_MAX);

    // Measurement FSM together with sticky error flags, error count and lock tracking.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            high_hold  <= '0;
            lock_cnt   <= '0;
            meas_high  <= '0;
            meas_low   <= '0;
            meas_valid <= 1'b0;
            period_err <= 1'b0;
            timeout    <= 1'b0;
            err_count  <= '0;
            locked     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;

            // A fresh error on the clearing cycle survives the clear.
            if (clear) begin
                period_err <= chk_bad;
                timeout    <= sat_hit;
                err_count  <= (chk_bad || sat_hit) ? ERR_W'(1) : '0;
            end else begin
                if (chk_bad) begin
                    period_err <= 1'b1;
                end
                if (sat_hit) begin
                    timeout <= 1'b1;
                end
                if ((chk_bad || sat_hit) && (err_count != ERR_MAX)) begin
                    err_count <= err_count + 1'b1;
                end
            end

            if (!enable || chk_bad || sat_hit) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else if (chk_good) begin
                if (lock_cnt != LOCK_TGT) begin
                    lock_cnt <= lock_cnt + 1'b1;
                end
                locked <= (lock_cnt >= (LOCK_TGT - 1'b1));
            end

            if (!enable) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SYNC;
                        cnt   <= '0;
                    end
                    SYNC: begin
                        if (rise) begin
                            state <= HIGH;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    HIGH: begin
                        if (sat_hit) begin
                            state <= SYNC;
                            cnt   <= '0;
                        end else if (fall) begin
                            high_hold <= cnt;
                            cnt       <= CNT_W'(1);
                            state     <= LOW;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    LOW: begin
                        if (sat_hit) begin
                            state <= SYNC;
                            cnt   <= '0;
                        end else if (rise) begin
                            meas_high  <= high_hold;
                            meas_low   <= cnt;
                            meas_valid <= 1'b1;
                            cnt        <= CNT_W'(1);
                            state      <= HIGH;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_period_monitor.sv
// tb/tb_clk_period_monitor.sv - scoreboard bench for clk_period_monitor
module tb_clk_period_monitor;
    import clk_mon_pkg::*;

    localparam int CNT_W = 8;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             enable;
    logic             clear;
    logic             sig_in;
    logic [CNT_W-1:0] meas_high;
    logic [CNT_W-1:0] meas_low;
    logic             meas_valid;
    logic             period_err;
    logic             timeout;
    logic [ERR_W-1:0] err_count;
    logic             locked;

    typedef struct {
        logic [CNT_W-1:0] h;
        logic [CNT_W-1:0] l;
        logic             pe;
        logic [7:0]       ec;
        logic             lk;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    int vh [10] = '{25, 25, 25, 25, 28, 25, 25, 25, 26, 24};
    int vl [10] = '{25, 25, 25, 25, 25, 25, 25, 25, 24, 26};
    int vpe[10] = '{ 0,  0,  0,  0,  1,  1,  1,  1,  1,  1};
    int vec[10] = '{ 0,  0,  0,  0,  1,  1,  1,  1,  1,  1};
    int vlk[10] = '{ 0,  0,  0,  1,  0,  0,  0,  0,  1,  1};

    clk_period_monitor #(
        .CNT_W    (CNT_W),
        .EXP_HIGH (25),
        .EXP_LOW  (25),
        .TOL      (1),
        .LOCK_N   (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .clear      (clear),
        .sig_in     (sig_in),
        .meas_high  (meas_high),
        .meas_low   (meas_low),
        .meas_valid (meas_valid),
        .period_err (period_err),
        .timeout    (timeout),
        .err_count  (err_count),
        .locked     (locked)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic period(input int h, input int l, input int pe, input int ec, input int lk);
        exp_t e;
        e.h  = CNT_W'(h);
        e.l  = CNT_W'(l);
        e.pe = 1'(pe);
        e.ec = 8'(ec);
        e.lk = 1'(lk);
        q.push_back(e);
        sig_in = 1'b1;
        repeat (h) @(negedge clock);
        sig_in = 1'b0;
        repeat (l) @(negedge clock);
    endtask

    task automatic clear_pulse();
        int n;
        n = 0;
        while (meas_valid !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("clear_wait_bound", 32'(n < 20), 32'd1);
        clear = 1'b1;
        @(negedge clock);
        @(negedge clock);
        clear = 1'b0;
        check("clear_alone_period_err", 32'(period_err), 32'd0);
        check("clear_alone_err_count", 32'(err_count), 32'd0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && meas_valid === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_meas_valid: got high=%0d low=%0d expected no pulse",
                             meas_high, meas_low);
                end else begin
                    e = q.pop_front();
                    check("meas_high", 32'(meas_high), 32'(e.h));
                    check("meas_low", 32'(meas_low), 32'(e.l));
                    @(negedge clock);
                    check("period_err", 32'(period_err), 32'(e.pe));
                    check("err_count", 32'(err_count), 32'(e.ec));
                    check("locked", 32'(locked), 32'(e.lk));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_at;
        reset_n = 1'b0;
        enable  = 1'b0;
        clear   = 1'b0;
        sig_in  = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_meas_high", 32'(meas_high), 32'd0);
        check("rst_meas_low", 32'(meas_low), 32'd0);
        check("rst_meas_valid", 32'(meas_valid), 32'd0);
        check("rst_period_err", 32'(period_err), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);

        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (5) @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            period(vh[i], vl[i], vpe[i], vec[i], vlk[i]);
        end
        period(25, 27, 1, 1, 0);
        fork
            period(25, 25, 0, 0, 0);
            clear_pulse();
        join
        period(25, 25, 0, 0, 0);
        period(25, 25, 0, 0, 0);
        period(25, 25, 0, 0, 1);
        sig_in = 1'b1;
        repeat (10) @(negedge clock);

        enable = 1'b0;
        @(negedge clock);
        check("disable_locked", 32'(locked), 32'd0);
        check("disable_keeps_meas_high", 32'(meas_high), 32'd25);
        check("disable_keeps_err_count", 32'(err_count), 32'd0);

        enable = 1'b1;
        sig_in = 1'b0;
        repeat (10) @(negedge clock);
        sig_in = 1'b1;
        t_at = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clock);
            if (timeout === 1'b1) begin
                t_at = i;
                break;
            end
        end
        check("timeout_cycle", 32'(t_at), 32'd259);
        check("timeout_err_count", 32'(err_count), 32'd1);
        check("timeout_period_err", 32'(period_err), 32'd0);
        check("timeout_locked", 32'(locked), 32'd0);
        check("timeout_state_sync", 32'(dut.state), 32'(SYNC));

        sig_in = 1'b0;
        repeat (30) @(negedge clock);
        sig_in = 1'b1;
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midrst_outputs",
              32'({meas_high, meas_low, meas_valid, period_err, timeout, err_count, locked}), 32'd0);
        check("midrst_state_idle", 32'(dut.state), 32'(IDLE));
        sig_in = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        period(25, 25, 0, 0, 0);
        period(25, 25, 0, 0, 0);
        sig_in = 1'b1;
        repeat (10) @(negedge clock);

        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_period_monitor.md
Name: clk_period_monitor

Overview:
- Synthesizable receiver-side counterpart to the team's testbench clock generators.
- Samples an asynchronous periodic input `sig_in` on the system clock. Measures its high and low phase widths in clock cycles and checks each full period against expected widths within a tolerance.
- Reports per-period measurements, sticky error flags, an error count and a lock indication.
- Sits at the top of clocked test fixtures, and in-chip wherever a generated clock or strobe needs health checking.

Parameters:
- CNT_W, 16: width of phase counters and measurement outputs.
- EXP_HIGH, 25: expected high-phase width, clock cycles.
- EXP_LOW, 25: expected low-phase width, clock cycles.
- TOL, 1: allowed absolute deviation per phase, cycles.
- LOCK_N, 4: consecutive good periods required to assert `locked`.

Ports:
- clock, input, 1: system clock; all state on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: monitor enable.
- clear, input, 1: synchronous clear of sticky flags and `err_count`.
- sig_in, input, 1: monitored signal, asynchronous to `clock`.
- meas_high, output, CNT_W: last completed high-phase width.
- meas_low, output, CNT_W: last completed low-phase width.
- meas_valid, output, 1: one-cycle pulse when `meas_high`/`meas_low` update.
- period_err, output, 1: sticky; some period was out of tolerance.
- timeout, output, 1: sticky; a phase counter saturated.
- err_count, output, 8: count of bad periods plus timeouts, saturating at 255.
- locked, output, 1: LOCK_N consecutive good periods seen.

Behaviour:
- Reset (`reset_n`=0, asynchronous): every output is 0, FSM goes to IDLE, counters and synchronizer flops are 0.
- Input path: `sig_in` passes through a 2-flop synchronizer, then a 1-flop edge detector.
  - A pin transition shows up as a rise or fall pulse 3 clocks later.
  - Measurement latency is constant, so it does not affect measured widths.
- Phase counter: loads 1 on the cycle an edge is detected, then increments once per clock.
  - The width of a phase is the counter value held on the cycle before the next edge.
- FSM states:
  - IDLE: `enable`=1 goes to SYNC.
  - SYNC: discards any partial phase; a rising edge goes to HIGH.
  - HIGH: a falling edge latches the high width into a holding register and goes to LOW.
  - LOW: a rising edge updates `meas_high` and `meas_low`, pulses `meas_valid`, runs the check, and goes to HIGH.
  - Any state: `enable`=0 goes to IDLE on the next clock. Counter is cleared, `locked` goes to 0, `meas_*`, sticky flags and `err_count` are retained.
- Check, done on the `meas_valid` cycle:
  - Good period: |high − EXP_HIGH| ≤ TOL and |low − EXP_LOW| ≤ TOL.
  - Compare as unsigned magnitude difference, computed at CNT_W+1 bits; no wrap.
  - Good: the lock counter increments, saturating at LOCK_N; `locked`=1 once it reaches LOCK_N.
  - Bad: `period_err` goes to 1, `err_count` increments (saturating), lock counter and `locked` go to 0.
- Saturation: if the phase counter reaches 2^CNT_W−1 in HIGH or LOW:
  - `timeout` goes to 1, `err_count` increments, `locked` goes to 0, FSM goes to SYNC.
  - No `meas_valid` is issued.
- `clear`: zeroes `period_err`, `timeout` and `err_count` on the next clock.
  - If a new error is detected in the same cycle, the error wins: flag set, `err_count`=1.
  - `clear` does not affect `locked` or the `meas_*` outputs.
- Edge detected in the same cycle `enable` falls: `enable` wins; no measurement is issued.
- Glitch shorter than 1 clock: may be missed; no requirement.
- Reset mid-measurement: the partial phase is discarded. After reset, the first measurement needs a rising edge seen from SYNC.

Decomposition:
- Package clk_mon_pkg contains:
  - typedef enum logic [1:0] {IDLE, SYNC, HIGH, LOW} mon_state_t
  - the `err_count` width constant (8)
  - default parameter constants
- One sub-module: sync_edge_det, holding the 2-flop synchronizer plus registered rise/fall pulse outputs. It takes `clock` and `reset_n`; reset clears all flops.

Test Plan (defaults; CNT_W=8 where noted):
- Square wave, 25 clocks high / 25 low, `enable`=1:
  - `meas_valid` pulses every 50 clocks after the first rising edge, with `meas_high`=25 and `meas_low`=25.
  - `locked`=1 on the 4th pulse; `period_err`=0 and `err_count`=0 throughout.
- Once locked, one period of 28 high / 25 low → `period_err`=1, `err_count`=1, `locked`=0. Four further good periods → `locked`=1 again.
- Period of 26 high / 24 low → within TOL, no error, lock counter advances.
- CNT_W=8, `sig_in` stuck high after a rising edge → after 255 clocks `timeout`=1 and `err_count`=1, FSM in SYNC, no `meas_valid`.
- `clear` asserted on the same cycle as a bad-period `meas_valid` → `period_err`=1, `err_count`=1. `clear` alone next cycle → both 0.
- `reset_n` pulsed low during HIGH → all outputs 0 immediately. After release, the next `meas_valid` comes only after a fresh rising edge and one full period (`meas_high`=25).
